// File: rtl/tmon_adc_ctrl_pkg.sv
// Shared definitions for the temperature-monitor ADC controller:
// sequencer state encodings, serial frame geometry and a counter-width helper.
package tmon_adc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_FRAME = 2'd2,
    ST_ACCUM = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int SCLK_EDGES = 2 * FRAME_BITS;

  // Bits needed for a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmon_adc_serial.sv
// Serial ADC frame engine: CS_N/SCLK generation, frame timing and MSB-first
// capture of one 16-bit frame per start request.
module tmon_adc_serial
  import tmon_adc_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  done,
  output logic [FRAME_BITS-1:0] data
);

  localparam int DIV_W  = cnt_width(CLK_DIV);
  localparam int EDGE_W = $clog2(SCLK_EDGES + 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      done     <= 1'b0;
      data     <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (adc_cs_n) begin
        if (start) begin
          adc_cs_n <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
        end
      end else if (edge_cnt == EDGE_W'(SCLK_EDGES)) begin
        // One extra cycle after the last SCLK fall before releasing CS_N.
        adc_cs_n <= 1'b1;
        done     <= 1'b1;
      end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
        div_cnt  <= '0;
        adc_sclk <= ~adc_sclk;
        edge_cnt <= edge_cnt + 1'b1;
        if (!adc_sclk) begin
          data <= {data[FRAME_BITS-2:0], adc_dout};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmon_adc_ctrl.sv
// AD22100 temperature monitor: sequences ADC frames, box-car averages
// 2^AVG_LOG2 samples and maintains an over-temperature flag with hysteresis.
module tmon_adc_ctrl
  import tmon_adc_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_GAP = 1000,
  parameter int AVG_LOG2   = 2,
  parameter int ADC_BITS   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_dout,
  input  logic [ADC_BITS-1:0] hi_thresh,
  input  logic [ADC_BITS-1:0] lo_thresh,
  output logic [ADC_BITS-1:0] temp_code,
  output logic                temp_valid,
  output logic                over_temp,
  output logic                busy
);

  localparam int ACC_W = ADC_BITS + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int GAP_W = cnt_width(SAMPLE_GAP);

  state_t                          state, state_nxt;
  logic [GAP_W-1:0]                gap_cnt;
  logic [ACC_W-1:0]                acc, acc_sum;
  logic [CNT_W-1:0]                smp_cnt, cnt_inc;
  logic [FRAME_BITS-1:0]           frame_data;
  logic [ADC_BITS-1:0]             sample, avg_code;
  logic [FRAME_BITS-ADC_BITS-1:0]  lead_unused;
  logic                            start, frame_done, gap_last, result_due;

  // Leading frame bits are dropped without checking them.
  assign sample      = frame_data[ADC_BITS-1:0];
  assign lead_unused = frame_data[FRAME_BITS-1:ADC_BITS];
  assign acc_sum     = acc + ACC_W'(sample);
  assign cnt_inc     = smp_cnt + 1'b1;
  assign result_due  = (cnt_inc == CNT_W'(1 << AVG_LOG2));
  assign avg_code    = acc_sum[ACC_W-1:AVG_LOG2];
  assign gap_last    = (gap_cnt == GAP_W'(SAMPLE_GAP - 1));
  assign start       = (state == ST_GAP) && enable && gap_last;

  tmon_adc_serial #(
    .CLK_DIV (CLK_DIV)
  ) u_serial (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .adc_dout (adc_dout),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .done     (frame_done),
    .data     (frame_data)
  );

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_GAP;
      ST_GAP: begin
        if (!enable)       state_nxt = ST_IDLE;
        else if (gap_last) state_nxt = ST_FRAME;
      end
      ST_FRAME: if (frame_done) state_nxt = ST_ACCUM;
      ST_ACCUM: state_nxt = enable ? ST_GAP : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      gap_cnt    <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
      temp_code  <= '0;
      temp_valid <= 1'b0;
      over_temp  <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      temp_valid <= 1'b0;
      gap_cnt    <= (state == ST_GAP && state_nxt == ST_GAP) ? gap_cnt + 1'b1 : '0;

      if (state == ST_ACCUM) begin
        if (result_due) begin
          acc        <= '0;
          smp_cnt    <= '0;
          temp_code  <= avg_code;
          temp_valid <= 1'b1;
          // Set wins over clear, so inverted thresholds cannot oscillate.
          if (avg_code >= hi_thresh)     over_temp <= 1'b1;
          else if (avg_code < lo_thresh) over_temp <= 1'b0;
        end else if (!enable) begin
          acc     <= '0;
          smp_cnt <= '0;
        end else begin
          acc     <= acc_sum;
          smp_cnt <= cnt_inc;
        end
      end else if (state == ST_GAP && !enable) begin
        acc     <= '0;
        smp_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmon_adc_ctrl.sv
// Self-checking bench for tmon_adc_ctrl: behavioural serial ADC models,
// a result scoreboard and one task per scenario.
`timescale 1ns/1ps
module tb_tmon_adc_ctrl;

  localparam int CLK_DIV    = 2;
  localparam int SAMPLE_GAP = 4;

  typedef struct packed {
    logic [11:0] code;
    logic        ot;
  } result_t;

  logic        clk = 1'b0;
  logic        rst, enable, adc_cs_n, adc_sclk, adc_dout;
  logic        temp_valid, over_temp, busy;
  logic [11:0] hi_thresh, lo_thresh, temp_code;

  logic        enable1, cs1, sclk1, dout1, valid1, ot1, busy1;
  logic [11:0] hi1, lo1, code1;

  logic [15:0] adc_q[$];
  logic [15:0] adc_word, word1;
  result_t     exp_q[$];
  result_t     mon_r;
  logic        ot_model;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          valid_run = 0;
  int          valid_seen = 0;

  always #5 clk = ~clk;

  tmon_adc_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_GAP(SAMPLE_GAP), .AVG_LOG2(2), .ADC_BITS(12)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_dout(adc_dout), .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .temp_code(temp_code),
    .temp_valid(temp_valid), .over_temp(over_temp), .busy(busy)
  );

  tmon_adc_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_GAP(SAMPLE_GAP), .AVG_LOG2(0), .ADC_BITS(12)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .adc_cs_n(cs1), .adc_sclk(sclk1),
    .adc_dout(dout1), .hi_thresh(hi1), .lo_thresh(lo1), .temp_code(code1),
    .temp_valid(valid1), .over_temp(ot1), .busy(busy1)
  );

  // ADC models: load a word on CS_N fall, shift out MSB first on each SCLK fall.
  always @(negedge adc_cs_n) begin
    if (adc_q.size() > 0) adc_word = adc_q.pop_front();
    else                  adc_word = 16'h0800;
    adc_dout = adc_word[15];
  end
  always @(negedge adc_sclk) if (!adc_cs_n) begin
    adc_word = {adc_word[14:0], 1'b0};
    adc_dout = adc_word[15];
  end
  always @(negedge cs1) begin
    word1 = 16'hF123;
    dout1 = word1[15];
  end
  always @(negedge sclk1) if (!cs1) begin
    word1 = {word1[14:0], 1'b0};
    dout1 = word1[15];
  end

  // Scoreboard consumer and TEMP_VALID pulse-width monitor.
  always @(negedge clk) begin
    if (temp_valid) begin
      valid_run++;
      valid_seen++;
      if (valid_run == 1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: temp_code=%h, no result expected", temp_code);
        end else begin
          mon_r = exp_q.pop_front();
          n_checks += 2;
          if (temp_code !== mon_r.code) begin
            n_fail++; $display("FAIL temp_code: got %h expected %h", temp_code, mon_r.code);
          end
          if (over_temp !== mon_r.ot) begin
            n_fail++; $display("FAIL over_temp: got %b expected %b (code %h)", over_temp, mon_r.ot, mon_r.code);
          end
        end
      end
    end else if (valid_run != 0) begin
      n_checks++;
      if (valid_run != 1) begin
        n_fail++; $display("FAIL valid_width: got %0d cycles expected 1", valid_run);
      end
      valid_run = 0;
    end
  end

  task automatic queue_block(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
    logic [13:0] sum;
    result_t     r;
    adc_q.push_back(w0); adc_q.push_back(w1); adc_q.push_back(w2); adc_q.push_back(w3);
    sum = {2'b00, w0[11:0]} + {2'b00, w1[11:0]} + {2'b00, w2[11:0]} + {2'b00, w3[11:0]};
    r.code = sum[13:2];
    if (r.code >= hi_thresh)     ot_model = 1'b1;
    else if (r.code < lo_thresh) ot_model = 1'b0;
    r.ot = ot_model;
    exp_q.push_back(r);
  endtask

  task automatic wait_cs_fall(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!adc_cs_n) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++; $display("FAIL cs_fall_timeout: no CS_N fall within %0d cycles", limit);
    end
  endtask

  // Observes one frame from CS_N fall to rise; optionally drops ENABLE at frame cycle drop_at.
  task automatic measure_frame(input int drop_at, output int low_cycles, output int rises,
                               output int first_rise, output int bad_period, output logic sclk_at_end);
    bit   ok;
    logic prev;
    int   last_rise;
    low_cycles = 0; rises = 0; first_rise = -1; bad_period = 0; last_rise = -1; sclk_at_end = 1'bx;
    wait_cs_fall(200, ok);
    if (ok) begin
      low_cycles = 1;
      prev = adc_sclk;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (adc_cs_n) begin sclk_at_end = adc_sclk; break; end
        low_cycles++;
        if (low_cycles - 1 == drop_at) enable = 1'b0;
        if (adc_sclk && !prev) begin
          if (rises == 0) first_rise = low_cycles - 1;
          else if (low_cycles - 1 - last_rise != 2 * CLK_DIV) bad_period++;
          last_rise = low_cycles - 1;
          rises++;
        end
        prev = adc_sclk;
      end
    end
  endtask

  task automatic wait_results(input int limit);
    int i;
    for (i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: %0d results still pending after %0d cycles", exp_q.size(), limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && busy; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; enable1 = 1'b0; adc_dout = 1'b0; dout1 = 1'b0;
    hi_thresh = 12'hFFF; lo_thresh = 12'h000; hi1 = 12'h123; lo1 = 12'h000; ot_model = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (adc_cs_n !== 1'b1)   begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    if (adc_sclk !== 1'b0)   begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
    if (temp_code !== 12'h0) begin n_fail++; $display("FAIL reset_code: got %h expected 000", temp_code); end
    if (temp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", temp_valid); end
    if (over_temp !== 1'b0)  begin n_fail++; $display("FAIL reset_ot: got %b expected 0", over_temp); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timing_avg();
    int   low, rises, first, bad;
    logic sclk_end;
    queue_block(16'h0800, 16'h0800, 16'h0800, 16'h0800);
    enable = 1'b1;
    measure_frame(-1, low, rises, first, bad, sclk_end);
    n_checks += 5;
    if (low != 65)         begin n_fail++; $display("FAIL cs_low_len: got %0d expected 65", low); end
    if (rises != 16)       begin n_fail++; $display("FAIL sclk_pulses: got %0d expected 16", rises); end
    if (first != CLK_DIV)  begin n_fail++; $display("FAIL first_rise: got %0d expected %0d", first, CLK_DIV); end
    if (bad != 0)          begin n_fail++; $display("FAIL sclk_period: got %0d bad periods expected 0", bad); end
    if (sclk_end !== 1'b0) begin n_fail++; $display("FAIL sclk_idle: got %b expected 0", sclk_end); end
    wait_results(2000);
    enable = 1'b0;
    wait_idle(300);
    n_checks++;
    if (temp_code !== 12'h800) begin n_fail++; $display("FAIL avg_hold: got %h expected 800", temp_code); end
  endtask

  task automatic test_truncation();
    queue_block(16'h0100, 16'h0101, 16'h0102, 16'h0104);
    enable = 1'b1;
    wait_results(2000);
    enable = 1'b0;
    wait_idle(300);
  endtask

  task automatic test_back_to_back_hysteresis();
    hi_thresh = 12'h900; lo_thresh = 12'h880;
    queue_block(16'h0900, 16'h0900, 16'h0900, 16'h0900);
    queue_block(16'h08A0, 16'h08A0, 16'h08A0, 16'h08A0);
    queue_block(16'h087F, 16'h087F, 16'h087F, 16'h087F);
    queue_block(16'h08FF, 16'h08FF, 16'h08FF, 16'h08FF);
    enable = 1'b1;
    wait_results(6000);
    enable = 1'b0;
    wait_idle(300);
    // Threshold changes alone must not re-evaluate the alarm.
    hi_thresh = 12'h100;
    repeat (5) @(negedge clk);
    n_checks++;
    if (over_temp !== 1'b0) begin n_fail++; $display("FAIL thresh_no_reeval: got %b expected 0", over_temp); end
    hi_thresh = 12'hFFF; lo_thresh = 12'h000;
  endtask

  task automatic test_enable_drop();
    int   low, rises, first, bad, seen_before;
    logic sclk_end;
    adc_q.push_back(16'h0400); adc_q.push_back(16'h0400);
    seen_before = valid_seen;
    enable = 1'b1;
    measure_frame(-1, low, rises, first, bad, sclk_end);
    measure_frame(10, low, rises, first, bad, sclk_end);
    wait_idle(300);
    n_checks += 4;
    if (low != 65)                 begin n_fail++; $display("FAIL drop_frame_len: got %0d expected 65", low); end
    if (valid_seen != seen_before) begin n_fail++; $display("FAIL drop_no_valid: got %0d pulses expected 0", valid_seen - seen_before); end
    if (temp_code !== 12'h8FF)     begin n_fail++; $display("FAIL drop_code_kept: got %h expected 8ff", temp_code); end
    if (adc_q.size() != 0)         begin n_fail++; $display("FAIL drop_frames: got %0d unused words expected 0", adc_q.size()); end
    // A fresh average needs four new frames; stale partial sums would give 0x300.
    hi_thresh = 12'h100;
    queue_block(16'h0200, 16'h0200, 16'h0200, 16'h0200);
    enable = 1'b1;
    wait_results(2000);
    enable = 1'b0;
    wait_idle(300);
    hi_thresh = 12'hFFF;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int n;
    adc_q.push_back(16'h0ABC);
    enable = 1'b1;
    wait_cs_fall(200, ok);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks += 6;
    if (adc_cs_n !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_cs_n: got %b expected 1", adc_cs_n); end
    if (adc_sclk !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_sclk: got %b expected 0", adc_sclk); end
    if (temp_code !== 12'h0) begin n_fail++; $display("FAIL mid_rst_code: got %h expected 000", temp_code); end
    if (temp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", temp_valid); end
    if (over_temp !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_ot: got %b expected 0", over_temp); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    ot_model = 1'b0;
    repeat (2) @(negedge clk);
    queue_block(16'h0333, 16'h0333, 16'h0333, 16'h0333);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!adc_cs_n) break;
    end
    n_checks++;
    if (n != SAMPLE_GAP + 1) begin n_fail++; $display("FAIL restart_gap: got %0d cycles expected %0d", n, SAMPLE_GAP + 1); end
    wait_results(2000);
    enable = 1'b0;
    wait_idle(300);
  endtask

  task automatic test_lead_mask();
    bit got;
    got = 1'b0;
    enable1 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid1) begin got = 1'b1; break; end
    end
    enable1 = 1'b0;
    n_checks += 2;
    if (!got || code1 !== 12'h123) begin
      n_fail++; $display("FAIL lead_mask: got %h (valid seen %b) expected 123", code1, got);
    end
    if (ot1 !== 1'b1) begin n_fail++; $display("FAIL hi_equal_sets: got %b expected 1", ot1); end
  endtask

  initial begin
    test_reset();
    test_timing_avg();
    test_truncation();
    test_back_to_back_hysteresis();
    test_enable_drop();
    test_reset_midframe();
    test_lead_mask();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
